// File: rtl/trap_pkg.sv
// Shared constants, FSM state type and mstatus rewrite helpers for the trap controller.
package trap_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMie     = 12'h304;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMip     = 12'h344;

  // Interrupt cause codes
  localparam logic [3:0] IrqCodeMsi = 4'd3;
  localparam logic [3:0] IrqCodeMti = 4'd7;
  localparam logic [3:0] IrqCodeMei = 4'd11;

  // mstatus bit positions
  localparam int unsigned MstatusMie   = 3;
  localparam int unsigned MstatusMpie  = 7;
  localparam int unsigned MstatusMppHi = 12;
  localparam int unsigned MstatusMppLo = 11;

  typedef enum logic [3:0] {
    StIdle,
    StRdStatus,
    StWrEpc,
    StWrCause,
    StWrStatus,
    StRedirect,
    StMretRd,
    StMretWr,
    StMretRedir
  } trap_state_e;

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- mpp
  function automatic logic [31:0] trap_entry_status(input logic [31:0] s, input logic [1:0] mpp);
    logic [31:0] r;
    r = s;
    r[MstatusMpie] = s[MstatusMie];
    r[MstatusMie] = 1'b0;
    r[MstatusMppHi:MstatusMppLo] = mpp;
    return r;
  endfunction

  // MRET: MIE <- MPIE, MPIE <- 1, MPP <- mpp
  function automatic logic [31:0] mret_status(input logic [31:0] s, input logic [1:0] mpp);
    logic [31:0] r;
    r = s;
    r[MstatusMie] = s[MstatusMpie];
    r[MstatusMpie] = 1'b1;
    r[MstatusMppHi:MstatusMppLo] = mpp;
    return r;
  endfunction

endpackage

// File: rtl/trap_irq_select.sv
// Combinational interrupt arbiter: decides whether an interrupt is takeable and which code wins.
module trap_irq_select
  import trap_pkg::*;
(
  input  logic       mstatus_mie_i,
  input  logic       mie_msie_i,
  input  logic       mie_mtie_i,
  input  logic       mie_meie_i,
  input  logic       mip_msip_i,
  input  logic       mip_mtip_i,
  input  logic       mip_meip_i,
  output logic       irq_take_o,
  output logic [3:0] irq_code_o
);

  logic msi_pend, mti_pend, mei_pend;

  assign msi_pend = mip_msip_i & mie_msie_i;
  assign mti_pend = mip_mtip_i & mie_mtie_i;
  assign mei_pend = mip_meip_i & mie_meie_i;

  // Fixed priority MEI > MSI > MTI, gated by the global enable
  always_comb begin
    irq_take_o = mstatus_mie_i & (msi_pend | mti_pend | mei_pend);
    irq_code_o = IrqCodeMti;
    if (mei_pend) begin
      irq_code_o = IrqCodeMei;
    end else if (msi_pend) begin
      irq_code_o = IrqCodeMsi;
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Trap/MRET sequencer owning the machine-mode CSR write port; stalls the core and redirects the PC.
module trap_controller
  import trap_pkg::*;
#(
  parameter logic [1:0] MPP_VALUE = 2'b11,
  parameter bit         VECTOR_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_csr_WE_L,
  input  logic [11:0] core_csr_address,
  input  logic [31:0] core_csr_write_data,
  output logic [31:0] core_csr_read_data,
  output logic        csr_WE_L,
  output logic [11:0] csr_address,
  output logic [31:0] csr_write_data,
  input  logic [31:0] csr_read_data,
  input  logic        mstatus_MIE,
  input  logic        mie_MSIE,
  input  logic        mie_MTIE,
  input  logic        mie_MEIE,
  input  logic        mip_MSIP,
  input  logic        mip_MTIP,
  input  logic        mip_MEIP,
  input  logic [1:0]  mtvec_MODE,
  input  logic [29:0] mtvec_BASE,
  input  logic [31:0] mepc_REG,
  input  logic        retire_valid,
  input  logic [31:0] next_pc,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        mret_valid,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  trap_state_e state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] status_q, status_d;

  logic        irq_take;
  logic [3:0]  irq_code;
  logic        irq_event;
  logic [31:0] trap_target;

  trap_irq_select u_irq_select (
    .mstatus_mie_i (mstatus_MIE),
    .mie_msie_i    (mie_MSIE),
    .mie_mtie_i    (mie_MTIE),
    .mie_meie_i    (mie_MEIE),
    .mip_msip_i    (mip_MSIP),
    .mip_mtip_i    (mip_MTIP),
    .mip_meip_i    (mip_MEIP),
    .irq_take_o    (irq_take),
    .irq_code_o    (irq_code)
  );

  // Interrupts are only taken at an instruction boundary
  assign irq_event = retire_valid & irq_take;

  assign core_csr_read_data = csr_read_data;

  // Vector target: base, plus 4*code for interrupts in vectored mode
  always_comb begin
    trap_target = {mtvec_BASE, 2'b00};
    if (VECTOR_EN && (mtvec_MODE == 2'b01) && cause_q[31]) begin
      trap_target = trap_target + {26'b0, cause_q[3:0], 2'b00};
    end
  end

  // Next-state, trap latch and CSR port / core control outputs
  always_comb begin
    state_d        = state_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    status_d       = status_q;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    csr_WE_L       = 1'b1;
    csr_address    = 12'h0;
    csr_write_data = 32'h0;

    unique case (state_q)
      StIdle: begin
        csr_WE_L       = core_csr_WE_L;
        csr_address    = core_csr_address;
        csr_write_data = core_csr_write_data;
        if (exc_valid) begin
          // The faulting instruction must not commit its CSR write
          csr_WE_L = 1'b1;
          stall    = 1'b1;
          epc_d    = exc_pc;
          cause_d  = {1'b0, 27'b0, exc_cause};
          state_d  = StRdStatus;
        end else if (irq_event) begin
          stall   = 1'b1;
          epc_d   = next_pc;
          cause_d = {1'b1, 27'b0, irq_code};
          state_d = StRdStatus;
        end else if (mret_valid) begin
          stall   = 1'b1;
          state_d = StMretRd;
        end
      end
      StRdStatus: begin
        stall       = 1'b1;
        csr_address = CsrMstatus;
        status_d    = csr_read_data;
        state_d     = StWrEpc;
      end
      StWrEpc: begin
        stall          = 1'b1;
        csr_WE_L       = 1'b0;
        csr_address    = CsrMepc;
        csr_write_data = epc_q;
        state_d        = StWrCause;
      end
      StWrCause: begin
        stall          = 1'b1;
        csr_WE_L       = 1'b0;
        csr_address    = CsrMcause;
        csr_write_data = cause_q;
        state_d        = StWrStatus;
      end
      StWrStatus: begin
        stall          = 1'b1;
        csr_WE_L       = 1'b0;
        csr_address    = CsrMstatus;
        csr_write_data = trap_entry_status(status_q, MPP_VALUE);
        state_d        = StRedirect;
      end
      StRedirect: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = trap_target;
        state_d        = StIdle;
      end
      StMretRd: begin
        stall       = 1'b1;
        csr_address = CsrMstatus;
        status_d    = csr_read_data;
        state_d     = StMretWr;
      end
      StMretWr: begin
        stall          = 1'b1;
        csr_WE_L       = 1'b0;
        csr_address    = CsrMstatus;
        csr_write_data = mret_status(status_q, MPP_VALUE);
        state_d        = StMretRedir;
      end
      StMretRedir: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = mepc_REG;
        state_d        = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Reset forces the quiet output state immediately, aborting any in-flight write
    if (reset) begin
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      csr_WE_L       = 1'b1;
      csr_address    = 12'h0;
      csr_write_data = 32'h0;
    end
  end

  // State and trap latch registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      epc_q    <= 32'h0;
      cause_q  <= 32'h0;
      status_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: scoreboard of CSR writes and redirects plus
// per-scenario stall/strobe checks.
module tb_trap_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        core_csr_WE_L;
  logic [11:0] core_csr_address;
  logic [31:0] core_csr_write_data;
  logic [31:0] core_csr_read_data;
  logic        csr_WE_L;
  logic [11:0] csr_address;
  logic [31:0] csr_write_data;
  logic [31:0] csr_read_data;
  logic        mstatus_MIE;
  logic        mie_MSIE, mie_MTIE, mie_MEIE;
  logic        mip_MSIP, mip_MTIP, mip_MEIP;
  logic [1:0]  mtvec_MODE;
  logic [29:0] mtvec_BASE;
  logic [31:0] mepc_REG;
  logic        retire_valid;
  logic [31:0] next_pc;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic        mret_valid;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] mstatus_val;
  int tests = 0;
  int fails = 0;
  logic [43:0] wr_q[$];
  logic [31:0] rd_q[$];

  always #5 clock = ~clock;

  // Simple CSR file read model
  assign csr_read_data = (csr_address == 12'h300) ? mstatus_val : (32'hA5A5_0000 | {20'h0, csr_address});

  trap_controller #(
    .MPP_VALUE (2'b11),
    .VECTOR_EN (1'b1)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .core_csr_WE_L       (core_csr_WE_L),
    .core_csr_address    (core_csr_address),
    .core_csr_write_data (core_csr_write_data),
    .core_csr_read_data  (core_csr_read_data),
    .csr_WE_L            (csr_WE_L),
    .csr_address         (csr_address),
    .csr_write_data      (csr_write_data),
    .csr_read_data       (csr_read_data),
    .mstatus_MIE         (mstatus_MIE),
    .mie_MSIE            (mie_MSIE),
    .mie_MTIE            (mie_MTIE),
    .mie_MEIE            (mie_MEIE),
    .mip_MSIP            (mip_MSIP),
    .mip_MTIP            (mip_MTIP),
    .mip_MEIP            (mip_MEIP),
    .mtvec_MODE          (mtvec_MODE),
    .mtvec_BASE          (mtvec_BASE),
    .mepc_REG            (mepc_REG),
    .retire_valid        (retire_valid),
    .next_pc             (next_pc),
    .exc_valid           (exc_valid),
    .exc_cause           (exc_cause),
    .exc_pc              (exc_pc),
    .mret_valid          (mret_valid),
    .stall               (stall),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    core_csr_WE_L = 1'b1; core_csr_address = 12'h0; core_csr_write_data = 32'h0;
    mstatus_MIE = 1'b0;
    mie_MSIE = 1'b0; mie_MTIE = 1'b0; mie_MEIE = 1'b0;
    mip_MSIP = 1'b0; mip_MTIP = 1'b0; mip_MEIP = 1'b0;
    mtvec_MODE = 2'b00; mtvec_BASE = 30'h80; mepc_REG = 32'h0;
    retire_valid = 1'b0; next_pc = 32'h0;
    exc_valid = 1'b0; exc_cause = 4'h0; exc_pc = 32'h0; mret_valid = 1'b0;
  endtask

  // Scoreboard: every CSR write strobe and redirect strobe must match the next expectation
  task automatic monitor();
    logic [43:0] ew;
    logic [31:0] er;
    forever begin
      @(negedge clock);
      if (csr_WE_L === 1'b0) begin
        tests++;
        if (wr_q.size() == 0) begin
          fails++;
          $display("FAIL csr_write unexpected: got addr=%h data=%h, none expected", csr_address,
                   csr_write_data);
        end else begin
          ew = wr_q.pop_front();
          if ({csr_address, csr_write_data} !== ew) begin
            fails++;
            $display("FAIL csr_write: got addr=%h data=%h, want addr=%h data=%h", csr_address,
                     csr_write_data, ew[43:32], ew[31:0]);
          end
        end
      end
      if (redirect_valid === 1'b1) begin
        tests++;
        if (rd_q.size() == 0) begin
          fails++;
          $display("FAIL redirect unexpected: got pc=%h", redirect_pc);
        end else begin
          er = rd_q.pop_front();
          if (redirect_pc !== er) begin
            fails++;
            $display("FAIL redirect_pc: got %h want %h", redirect_pc, er);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    mstatus_val = 32'h8;
    reset = 1'b1;
    core_csr_WE_L = 1'b0; core_csr_address = 12'h305; core_csr_write_data = 32'h1111_2222;
    step(); step();
    @(negedge clock);
    tests++;
    if ({stall, redirect_valid, csr_WE_L} !== 3'b001) begin
      fails++;
      $display("FAIL reset_ctl: got stall/redir/we_l=%b%b%b want 001", stall, redirect_valid,
               csr_WE_L);
    end
    tests++;
    if (csr_address !== 12'h0 || csr_write_data !== 32'h0 || redirect_pc !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got addr=%h data=%h rpc=%h want 0", csr_address, csr_write_data,
               redirect_pc);
    end
    tests++;
    if (core_csr_read_data !== 32'hA5A5_0000) begin
      fails++;
      $display("FAIL reset_rdata: got %h want a5a50000", core_csr_read_data);
    end
    step();
    reset = 1'b0;
    core_csr_WE_L = 1'b1;
  endtask

  task automatic test_exception();
    idle_inputs();
    mstatus_val = 32'h8; mtvec_BASE = 30'h80; mtvec_MODE = 2'b00;
    step();
    exc_valid = 1'b1; exc_cause = 4'h2; exc_pc = 32'h100;
    core_csr_WE_L = 1'b0; core_csr_address = 12'h305; core_csr_write_data = 32'hDEAD_BEEF;
    wr_q.push_back({12'h341, 32'h100});
    wr_q.push_back({12'h342, 32'h2});
    wr_q.push_back({12'h300, 32'h1880});
    rd_q.push_back(32'h200);
    @(negedge clock);
    tests++;
    if (stall !== 1'b1 || csr_WE_L !== 1'b1) begin
      fails++;
      $display("FAIL exc_detect: got stall=%b we_l=%b want 1 1", stall, csr_WE_L);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) begin
        exc_valid = 1'b0; core_csr_WE_L = 1'b1;
      end
      @(negedge clock);
      tests++;
      if (stall !== 1'b1 || redirect_valid !== (i == 5)) begin
        fails++;
        $display("FAIL exc_seq cyc%0d: got stall=%b redir=%b want 1 %b", i, stall, redirect_valid,
                 (i == 5));
      end
    end
    step();
    @(negedge clock);
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL exc_release: got stall=%b want 0", stall);
    end
  endtask

  task automatic test_vectored_irq();
    idle_inputs();
    mstatus_val = 32'h8; mstatus_MIE = 1'b1;
    mie_MEIE = 1'b1; mip_MEIP = 1'b1; mie_MTIE = 1'b1; mip_MTIP = 1'b1;
    mtvec_BASE = 30'hC0; mtvec_MODE = 2'b01;
    step();
    retire_valid = 1'b1; next_pc = 32'h44;
    wr_q.push_back({12'h341, 32'h44});
    wr_q.push_back({12'h342, 32'h8000_000B});
    wr_q.push_back({12'h300, 32'h1880});
    rd_q.push_back(32'h32C);
    @(negedge clock);
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("FAIL irq_detect: got stall=%b want 1", stall);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) begin
        retire_valid = 1'b0; mip_MEIP = 1'b0; mip_MTIP = 1'b0;
      end
      @(negedge clock);
      tests++;
      if (stall !== 1'b1 || redirect_valid !== (i == 5)) begin
        fails++;
        $display("FAIL irq_seq cyc%0d: got stall=%b redir=%b want 1 %b", i, stall, redirect_valid,
                 (i == 5));
      end
    end
    step();
  endtask

  task automatic test_masked_irq();
    idle_inputs();
    mstatus_MIE = 1'b0; mie_MTIE = 1'b1; mip_MTIP = 1'b1; retire_valid = 1'b1;
    core_csr_WE_L = 1'b0; core_csr_address = 12'h305; core_csr_write_data = 32'h1234_5601;
    wr_q.push_back({12'h305, 32'h1234_5601});
    @(negedge clock);
    tests++;
    if (stall !== 1'b0 || csr_WE_L !== 1'b0) begin
      fails++;
      $display("FAIL masked_pass: got stall=%b we_l=%b want 0 0", stall, csr_WE_L);
    end
    step();
    core_csr_WE_L = 1'b1;
    @(negedge clock);
    tests++;
    if (stall !== 1'b0 || redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL masked_quiet: got stall=%b redir=%b want 0 0", stall, redirect_valid);
    end
    step();
  endtask

  task automatic test_mret();
    idle_inputs();
    mstatus_val = 32'h1880; mepc_REG = 32'h44;
    mret_valid = 1'b1;
    wr_q.push_back({12'h300, 32'h1888});
    rd_q.push_back(32'h44);
    for (int i = 1; i <= 3; i++) begin
      step();
      mret_valid = 1'b0;
      @(negedge clock);
      tests++;
      if (stall !== 1'b1 || redirect_valid !== (i == 3)) begin
        fails++;
        $display("FAIL mret_seq cyc%0d: got stall=%b redir=%b want 1 %b", i, stall, redirect_valid,
                 (i == 3));
      end
    end
    step();
    @(negedge clock);
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL mret_release: got stall=%b want 0", stall);
    end
  endtask

  task automatic test_reset_abort();
    idle_inputs();
    mstatus_val = 32'h8;
    exc_valid = 1'b1; exc_cause = 4'h4; exc_pc = 32'h2F0;
    wr_q.push_back({12'h341, 32'h2F0});
    step();  // RD_STATUS
    exc_valid = 1'b0;
    step();  // WR_EPC
    step();  // WR_CAUSE, with reset
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (stall !== 1'b0 || csr_WE_L !== 1'b1) begin
      fails++;
      $display("FAIL abort_reset: got stall=%b we_l=%b want 0 1", stall, csr_WE_L);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      tests++;
      if (stall !== 1'b0 || redirect_valid !== 1'b0) begin
        fails++;
        $display("FAIL abort_idle cyc%0d: got stall=%b redir=%b want 0 0", i, stall,
                 redirect_valid);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    mstatus_val = 32'h8; mstatus_MIE = 1'b1; mtvec_BASE = 30'h80; mtvec_MODE = 2'b00;
    mie_MSIE = 1'b1; mip_MSIP = 1'b1; retire_valid = 1'b1; next_pc = 32'h184;
    exc_valid = 1'b1; exc_cause = 4'h5; exc_pc = 32'h180;
    wr_q.push_back({12'h341, 32'h180});
    wr_q.push_back({12'h342, 32'h5});
    wr_q.push_back({12'h300, 32'h1880});
    rd_q.push_back(32'h200);
    wr_q.push_back({12'h341, 32'h184});
    wr_q.push_back({12'h342, 32'h8000_0003});
    wr_q.push_back({12'h300, 32'h1880});
    rd_q.push_back(32'h200);
    for (int i = 0; i <= 11; i++) begin
      @(negedge clock);
      tests++;
      if (stall !== 1'b1 || redirect_valid !== (i == 5 || i == 11)) begin
        fails++;
        $display("FAIL b2b cyc%0d: got stall=%b redir=%b want 1 %b", i, stall, redirect_valid,
                 (i == 5 || i == 11));
      end
      step();
      exc_valid = 1'b0;
      if (i == 6) begin
        retire_valid = 1'b0; mip_MSIP = 1'b0;
      end
    end
    @(negedge clock);
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL b2b_release: got stall=%b want 0", stall);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_exception();
    test_vectored_irq();
    test_masked_irq();
    test_mret();
    test_reset_abort();
    test_back_to_back();
    step(); step();
    tests++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d writes %0d redirects left, want 0 0", wr_q.size(),
               rd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
